regfile_scoreboard_bypass: RTL and testbench

//  Parametrised integer register file for the pipelined core: NREAD combinational read ports,
//  one write port with optional write-to-read bypass, and a per-register busy scoreboard
//  (reserve at issue, clear on writeback) for hazard detection. A software/debug-triggered

---
 rtl/regfile_pkg.sv | 18 +
 rtl/rf_busy_table.sv | 38 +++
 rtl/regfile_scoreboard_bypass.sv | 117 +++++++++++
 tb/tb_regfile_scoreboard_bypass.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file with busy scoreboard.
// Imported by the top and by the busy-table sub-module.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // Low bit of port p inside a flattened multi-port bus of width-bit lanes.
  function automatic int slice_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_busy_table.sv
// Per-register busy bits: set on reserve, cleared on release or clear-all.
// Bit 0 never reads busy because register 0 is hardwired to zero.
module rf_busy_table
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             rel_en_i,
  input  logic [AW-1:0]    rel_addr_i,
  input  logic             clr_all_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Set is applied after release so a same-address reserve leaves the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (rel_en_i) busy_d[rel_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    if (clr_all_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_scoreboard_bypass.sv
// Register file with combinational read ports, optional write-to-read bypass,
// a busy scoreboard and a one-register-per-cycle clear sweep.
module regfile_scoreboard_bypass
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NREAD*$clog2(NREGS)-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0]            rd_data,
  output logic [NREAD-1:0]                 rd_busy,
  input  logic                             wr_en,
  input  logic [$clog2(NREGS)-1:0]         wr_addr,
  input  logic [XLEN-1:0]                  wr_data,
  input  logic                             rsv_en,
  input  logic [$clog2(NREGS)-1:0]         rsv_addr,
  input  logic                             clr_req,
  output logic                             ready
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_t        state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;
  logic             idle;
  logic             wrValid;
  logic             rsvValid;

  assign idle     = (state_q == RF_IDLE);
  assign ready    = idle;
  assign wrValid  = idle && wr_en && (wr_addr != '0);
  assign rsvValid = idle && rsv_en && (rsv_addr != '0);

  rf_busy_table #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_busy (
    .clock      (clock),
    .reset      (reset),
    .set_en_i   (rsvValid),
    .set_addr_i (rsv_addr),
    .rel_en_i   (wrValid),
    .rel_addr_i (wr_addr),
    .clr_all_i  (idle && clr_req),
    .busy_o     (busy)
  );

  // Sweep counter starts at 1 since register 0 never holds anything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = AW'(1);
        end
      end
      RF_CLEAR: begin
        if (cnt_q == LAST) state_d = RF_IDLE;
        else               cnt_d   = cnt_q + AW'(1);
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (idle) begin
      if (wrValid) regs_q[wr_addr] <= wr_data;
    end else begin
      regs_q[cnt_q] <= '0;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = rd_addr[slice_lsb(p, AW) +: AW];

    always_comb begin
      data = regs_q[addr];
      bsy  = busy[addr] && idle;
      if (addr == '0) begin
        data = '0;
        bsy  = 1'b0;
      end else if ((BYPASS != 0) && wrValid && (wr_addr == addr)) begin
        data = wr_data;
        bsy  = 1'b0;
      end
    end

    assign rd_data[slice_lsb(p, XLEN) +: XLEN] = data;
    assign rd_busy[p]                           = bsy;
  end

endmodule

// File: tb/tb_regfile_scoreboard_bypass.sv
// Directed bench: two instances (bypass on/off) share stimulus, checked with immediate assertions.
module tb_regfile_scoreboard_bypass;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  rdAddr;
  logic [63:0] rdData, rdDataNb;
  logic [1:0]  rdBusy, rdBusyNb;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic        rsvEn;
  logic [4:0]  rsvAddr;
  logic        clrReq;
  logic        ready, readyNb;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clock = ~clock;

  regfile_scoreboard_bypass #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut (
    .clock(clock), .reset(reset), .rd_addr(rdAddr), .rd_data(rdData), .rd_busy(rdBusy),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .rsv_en(rsvEn), .rsv_addr(rsvAddr),
    .clr_req(clrReq), .ready(ready)
  );

  regfile_scoreboard_bypass #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dutNb (
    .clock(clock), .reset(reset), .rd_addr(rdAddr), .rd_data(rdDataNb), .rd_busy(rdBusyNb),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .rsv_en(rsvEn), .rsv_addr(rsvAddr),
    .clr_req(clrReq), .ready(readyNb)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge and are held through the next rising edge.
  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic re, input logic [4:0] ra, input logic clr,
                               input logic [4:0] a0, input logic [4:0] a1);
    wrEn = we; wrAddr = wa; wrData = wd;
    rsvEn = re; rsvAddr = ra; clrReq = clr;
    rdAddr = {a1, a0};
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idleRead(input logic [4:0] a0, input logic [4:0] a1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, a0, a1);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    idleRead(5'd5, 5'd7);
    checkOutput("reset_ready", {31'b0, ready}, 32'h1);
    checkOutput("reset_r5", rdData[31:0], 32'h0);
    checkOutput("reset_busy", {30'b0, rdBusy}, 32'h0);

    // Plain write then read
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
    checkOutput("nb_r5_before_edge", rdDataNb[31:0], 32'h0);
    tick();
    idleRead(5'd5, 5'd0);
    checkOutput("r5_data", rdData[31:0], 32'hDEADBEEF);
    checkOutput("r5_busy", {31'b0, rdBusy[0]}, 32'h0);
    checkOutput("nb_r5_data", rdDataNb[31:0], 32'hDEADBEEF);

    // Same-cycle bypass on port 1
    applyStimulus(1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    checkOutput("bypass_r7", rdData[63:32], 32'h1234);
    checkOutput("bypass_r7_busy", {31'b0, rdBusy[1]}, 32'h0);
    checkOutput("nobypass_r7", rdDataNb[63:32], 32'h0);
    tick();
    idleRead(5'd0, 5'd7);
    checkOutput("r7_stored", rdData[63:32], 32'h1234);
    checkOutput("nb_r7_stored", rdDataNb[63:32], 32'h1234);

    // Reserve, then write+reserve same address, then release
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
    checkOutput("r3_busy_pre", {31'b0, rdBusy[0]}, 32'h0);
    tick();
    idleRead(5'd3, 5'd0);
    checkOutput("r3_busy_set", {31'b0, rdBusy[0]}, 32'h1);
    applyStimulus(1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
    checkOutput("r3_bypass_data", rdData[31:0], 32'h55);
    checkOutput("r3_bypass_busy", {31'b0, rdBusy[0]}, 32'h0);
    checkOutput("nb_r3_busy", {31'b0, rdBusyNb[0]}, 32'h1);
    tick();
    idleRead(5'd3, 5'd0);
    checkOutput("r3_data_55", rdData[31:0], 32'h55);
    checkOutput("r3_busy_kept", {31'b0, rdBusy[0]}, 32'h1);
    applyStimulus(1'b1, 5'd3, 32'h66, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    idleRead(5'd3, 5'd0);
    checkOutput("r3_data_66", rdData[31:0], 32'h66);
    checkOutput("r3_busy_clear", {31'b0, rdBusy[0]}, 32'h0);

    // Write and reserve to different registers in the same cycle
    applyStimulus(1'b1, 5'd4, 32'hA, 1'b1, 5'd6, 1'b0, 5'd0, 5'd0);
    tick();
    idleRead(5'd4, 5'd6);
    checkOutput("r4_data", rdData[31:0], 32'hA);
    checkOutput("r4_r6_busy", {30'b0, rdBusy}, 32'h2);

    // Register 0 ignores writes and reserves
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    checkOutput("r0_no_bypass", rdData[31:0], 32'h0);
    tick();
    idleRead(5'd0, 5'd0);
    checkOutput("r0_data", rdData[31:0], 32'h0);
    checkOutput("r0_busy", {31'b0, rdBusy[0]}, 32'h0);

    // Fill r1..r31 and make r3 busy before the sweep
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h1000_0000 | 32'(i), 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd9, 5'd31);
    checkOutput("fill_r9", rdData[31:0], 32'h1000_0009);
    checkOutput("fill_r31", rdData[63:32], 32'h1000_001F);
    tick();
    idleRead(5'd3, 5'd0);
    checkOutput("pre_clr_r3_busy", {31'b0, rdBusy[0]}, 32'h1);

    // Clear request together with a write to r2; the sweep must wipe it
    applyStimulus(1'b1, 5'd2, 32'hBBBB, 1'b1, 5'd3, 1'b1, 5'd2, 5'd0);
    checkOutput("clr_cycle_ready", {31'b0, ready}, 32'h1);
    tick();
    for (int k = 0; k < 31; k++) begin
      applyStimulus(1'b1, 5'd9, 32'hCAFE, 1'b1, 5'd9, 1'b1, 5'd9, 5'd3);
      checkOutput($sformatf("sweep_ready_%0d", k), {31'b0, ready}, 32'h0);
      checkOutput($sformatf("sweep_r9_%0d", k), rdData[31:0],
                  (k <= 8) ? 32'h1000_0009 : 32'h0);
      checkOutput($sformatf("sweep_busy_%0d", k), {30'b0, rdBusy}, 32'h0);
      tick();
    end
    idleRead(5'd0, 5'd0);
    checkOutput("post_sweep_ready", {31'b0, ready}, 32'h1);
    checkOutput("post_sweep_ready_nb", {31'b0, readyNb}, 32'h1);
    for (int i = 1; i < 32; i++) begin
      idleRead(5'(i), 5'(i));
      checkOutput($sformatf("post_sweep_r%0d", i), rdData[31:0], 32'h0);
      checkOutput($sformatf("post_sweep_busy_r%0d", i), {31'b0, rdBusy[1]}, 32'h0);
    end

    // Reset in the middle of a sweep
    applyStimulus(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd5, 32'h5, 1'b1, 5'd12, 1'b0, 5'd0, 5'd0);
    tick();
    idleRead(5'd20, 5'd12);
    checkOutput("pre_reset_r20", rdData[31:0], 32'h2020);
    checkOutput("pre_reset_r12_busy", {31'b0, rdBusy[1]}, 32'h1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0);
    tick();
    for (int k = 0; k < 9; k++) begin
      idleRead(5'd20, 5'd12);
      tick();
    end
    idleRead(5'd20, 5'd12);
    checkOutput("sweep10_ready", {31'b0, ready}, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idleRead(5'd20, 5'd5);
    checkOutput("after_reset_ready", {31'b0, ready}, 32'h1);
    checkOutput("after_reset_r20", rdData[31:0], 32'h0);
    checkOutput("after_reset_r5", rdData[63:32], 32'h0);
    idleRead(5'd12, 5'd20);
    checkOutput("after_reset_busy", {30'b0, rdBusy}, 32'h0);
    tick();
    idleRead(5'd0, 5'd0);
    checkOutput("after_reset_stays_idle", {31'b0, ready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
